// File: rtl/minisrc_pkg.sv
// Shared opcode constants, sequencer state encoding and instruction classes
// for the control sequencer.
package minisrc_pkg;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_HALT  = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP    = 4'd0,
        CLS_ALU3   = 4'd1,
        CLS_MULDIV = 4'd2,
        CLS_UNARY  = 4'd3,
        CLS_MFHI   = 4'd4,
        CLS_MFLO   = 4'd5,
        CLS_IN     = 4'd6,
        CLS_OUT    = 4'd7,
        CLS_HALT   = 4'd8
    } op_class_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Final step of each instruction class; that is where Stop is honoured.
    function automatic state_t last_step(input op_class_t cls);
        case (cls)
            CLS_ALU3:   return ST_T5;
            CLS_MULDIV: return ST_T6;
            CLS_UNARY:  return ST_T4;
            CLS_MFHI,
            CLS_MFLO,
            CLS_IN,
            CLS_OUT:    return ST_T3;
            default:    return ST_T2;
        endcase
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational map from a 5-bit opcode to its execution class.
module opcode_decoder
    import minisrc_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [3:0] op_class
);

    always_comb begin
        op_class = CLS_NOP;
        if (opcode >= OP_ADD && opcode <= OP_SHL) begin
            op_class = CLS_ALU3;
        end else begin
            case (opcode)
                OP_DIV, OP_MUL: op_class = CLS_MULDIV;
                OP_NEG, OP_NOT: op_class = CLS_UNARY;
                OP_MFHI:        op_class = CLS_MFHI;
                OP_MFLO:        op_class = CLS_MFLO;
                OP_IN:          op_class = CLS_IN;
                OP_OUT:         op_class = CLS_OUT;
                OP_HALT:        op_class = CLS_HALT;
                default:        op_class = CLS_NOP;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: steps RESET/T0..T6/HALT and decodes datapath control
// strobes from the current step and the opcode held in IR_Data.
module control_sequencer
    import minisrc_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_Data,
    input  logic        Stop,
    output logic        Run,
    output logic        PC_in,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        HI_in,
    output logic        LO_in,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic        OutPort_in,
    output logic        IncPC,
    output logic        PC_out,
    output logic        Zhigh_out,
    output logic        Zlow_out,
    output logic        HI_out,
    output logic        LO_out,
    output logic        MDR_out,
    output logic        InPort_out,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  alu_instruction_bits
);

    state_t     state_reg;
    logic [4:0] opcode;
    logic [3:0] class_bits;
    op_class_t  op_class;
    logic       unused_ir;

    assign opcode    = IR_Data[31:27];
    assign op_class  = op_class_t'(class_bits);
    assign unused_ir = ^IR_Data[26:0];

    opcode_decoder u_decoder (
        .opcode   (opcode),
        .op_class (class_bits)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= ST_RESET;
        end else begin
            case (state_reg)
                ST_RESET: state_reg <= ST_T0;
                ST_HALT:  state_reg <= ST_HALT;
                default: begin
                    // >= also recovers if IR changed under a longer instruction
                    if (state_reg >= last_step(op_class)) begin
                        state_reg <= (op_class == CLS_HALT || Stop) ? ST_HALT : ST_T0;
                    end else begin
                        state_reg <= state_t'(state_reg + 4'd1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        Run = 1'b0;  PC_in = 1'b0;  IR_in = 1'b0;  Y_in = 1'b0;  Z_in = 1'b0;
        HI_in = 1'b0;  LO_in = 1'b0;  MAR_in = 1'b0;  MDR_in = 1'b0;
        OutPort_in = 1'b0;  IncPC = 1'b0;  PC_out = 1'b0;  Zhigh_out = 1'b0;
        Zlow_out = 1'b0;  HI_out = 1'b0;  LO_out = 1'b0;  MDR_out = 1'b0;
        InPort_out = 1'b0;  Read = 1'b0;  Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;
        Rin = 1'b0;  Rout = 1'b0;  alu_instruction_bits = 5'd0;
        Run = (state_reg != ST_RESET) && (state_reg != ST_HALT);
        case (state_reg)
            ST_T0: begin PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1; end
            ST_T1: begin Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1; end
            ST_T2: begin MDR_out = 1'b1; IR_in = 1'b1; end
            ST_T3: begin
                case (op_class)
                    CLS_ALU3:   begin Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
                    CLS_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
                    CLS_UNARY:  begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = opcode; end
                    CLS_MFHI:   begin Gra = 1'b1; Rin = 1'b1; HI_out = 1'b1; end
                    CLS_MFLO:   begin Gra = 1'b1; Rin = 1'b1; LO_out = 1'b1; end
                    CLS_IN:     begin Gra = 1'b1; Rin = 1'b1; InPort_out = 1'b1; end
                    CLS_OUT:    begin Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1; end
                    default:    ;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CLS_ALU3:   begin Grc = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = opcode; end
                    CLS_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = opcode; end
                    CLS_UNARY:  begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default:    ;
                endcase
            end
            ST_T5: begin
                case (op_class)
                    CLS_ALU3:   begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_MULDIV: begin Zlow_out = 1'b1; LO_in = 1'b1; end
                    default:    ;
                endcase
            end
            ST_T6: begin
                if (op_class == CLS_MULDIV) begin
                    Zhigh_out = 1'b1;
                    HI_in     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, clr.
REQ-002 clk  input  1  rising-edge clock; all state updates occur on its rising edge.
REQ-003 clr  input  1  synchronous active-high reset.
REQ-004 IR_Data  input  32  current instruction register contents; opcode = IR_Data[31:27].
REQ-005 Stop  input  1  halt request, honoured at the next instruction boundary.
REQ-006 Run  output  1  high while executing; low in RESET and HALT.
REQ-007 PC_in  output  1  load PC from bus.
REQ-008 IR_in  output  1  load IR from bus.
REQ-009 Y_in  output  1  load Y from bus.
REQ-010 Z_in  output  1  load Z from ALU.
REQ-011 HI_in  output  1  load HI from bus.
REQ-012 LO_in  output  1  load LO from bus.
REQ-013 MAR_in  output  1  load MAR from bus.
REQ-014 MDR_in  output  1  load MDR.
REQ-015 OutPort_in  output  1  load output port from bus.
REQ-016 IncPC  output  1  ALU computes PC+1.
REQ-017 PC_out  output  1  drive PC onto bus.
REQ-018 Zhigh_out  output  1  drive Z[63:32] onto bus.
REQ-019 Zlow_out  output  1  drive Z[31:0] onto bus.
REQ-020 HI_out  output  1  drive HI onto bus.
REQ-021 LO_out  output  1  drive LO onto bus.
REQ-022 MDR_out  output  1  drive MDR onto bus.
REQ-023 InPort_out  output  1  drive input port onto bus.
REQ-024 Read  output  1  memory read strobe into MDR.
REQ-025 Gra  output  1  select register Ra field.
REQ-026 Grb  output  1  select register Rb field.
REQ-027 Grc  output  1  select register Rc field.
REQ-028 Rin  output  1  write the selected register from bus.
REQ-029 Rout  output  1  drive the selected register onto bus.
REQ-030 alu_instruction_bits  output  5  ALU operation; equals the opcode in ALU steps and 0 otherwise.

Function
REQ-031 The state register SHALL hold RESET, T0..T6, or HALT; it advances one state per clk, and outputs are decoded combinationally from state and opcode, so every unlisted output is 0.
REQ-032 Fetch SHALL be: T0 = PC_out, MAR_in, IncPC, Z_in; T1 = Zlow_out, PC_in, Read, MDR_in; T2 = MDR_out, IR_in.
REQ-033 add(00011) through shl(01011) SHALL execute as: T3 = Grb, Rout, Y_in; T4 = Grc, Rout, Z_in, opcode; T5 = Zlow_out, Gra, Rin; then T0, for 6 cycles per instruction.
REQ-034 div(01111) and mul(10000) SHALL execute as: T3 = Gra, Rout, Y_in; T4 = Grb, Rout, Z_in, opcode; T5 = Zlow_out, LO_in; T6 = Zhigh_out, HI_in; then T0.
REQ-035 neg(10001) and not(10010) SHALL execute as: T3 = Grb, Rout, Z_in, opcode; T4 = Zlow_out, Gra, Rin; then T0.
REQ-036 Single-step instructions SHALL use T3 then T0: mfhi(11000) = Gra, Rin, HI_out; mflo(11001) = Gra, Rin, LO_out; in(10110) = Gra, Rin, InPort_out; out(10111) = Gra, Rout, OutPort_in.
REQ-037 nop(11010) and every unlisted opcode SHALL go from T2 directly to T0.
REQ-038 halt(11011) SHALL go from T2 to HALT; HALT holds with all outputs 0 until clr.
REQ-039 Stop high at any instruction's last step SHALL enter HALT instead of T0; Stop elsewhere SHALL have no effect until that step.

Reset
REQ-040 While clr is high at a clk edge, state SHALL become RESET with every output 0; this applies mid-instruction, and the partial instruction is abandoned.
REQ-041 RESET SHALL go to T0 on the first edge with clr low.

Structure
REQ-042 Opcode constants and the state encoding SHALL live in the shared package minisrc_pkg.
REQ-043 The opcode-to-class decode SHALL be the single sub-module opcode_decoder (combinational).

Verification
REQ-044 IR=0xCB000000 (mflo R6): T3 SHALL assert Gra, Rin, LO_out, and the sequence SHALL return to T0 after 4 cycles.
REQ-045 IR=0x18918000 (add): T4 SHALL assert Grc, Rout, Z_in with alu_instruction_bits=00011, then Zlow_out, Gra, Rin, for 6 cycles total.
REQ-046 IR=0x80000000 (mul): T5 SHALL assert Zlow_out, LO_in and T6 Zhigh_out, HI_in, for 7 cycles total.
REQ-047 IR=0xD8000000 (halt): Run SHALL fall after T2 and all outputs SHALL stay 0 for 10 further cycles; then clr SHALL restart the sequence at T0.
REQ-048 clr asserted during T4 of add: the next cycle SHALL be RESET with all outputs 0, followed by T0.
